// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid-buffered pipeline register with flush and stall counter
module pipe_skid_reg #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // main drives the outputs and always holds the older entry; skid catches
   // the one entry that arrives while main is blocked downstream
   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

   logic accept;
   logic pop;
   logic stalled;

   // in_ready comes straight from the skid valid flop, so out_ready never
   // reaches the upstream handshake combinationally
   assign in_ready  = ~skid_valid_q;
   assign accept    = in_valid & in_ready;
   assign pop       = main_valid_q & out_ready;
   assign stalled   = in_valid & ~in_ready;

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   // bubbles must never carry RegWrite/Jump/MemtoReg downstream
   assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign stall_cnt = stall_cnt_q;

   // entry movement between input, skid and main; flush wins over everything
   // but only drops valid bits, payload flops keep their contents
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // in_ready is low here, so the only possible event is a pop
         if (pop) begin
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q || pop) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
         end
      end else if (pop) begin
         main_valid_d = 1'b0;
      end
   end

   // saturating count of cycles where upstream offered an entry and was refused
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stalled && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // state registers; reset abandons any held entries immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 69, meaning payload width (read_data 32 + alu_result 32 + Dest 5).
REQ-002 SHALL have parameter CTRL_W, default 3, meaning control-field width (RegWrite, Jump, MemtoReg).
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width (min 1).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream stage presents an entry.
REQ-008 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 SHALL have port out_valid  output  1  downstream entry valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts entry.
REQ-013 SHALL have port out_data  output  DATA_W  held payload.
REQ-014 SHALL have port out_ctrl  output  CTRL_W  held control, gated by validity.
REQ-015 SHALL have port occupancy  output  2  entries held (0..2).
REQ-016 SHALL have port stall_cnt  output  CNT_W  saturating count of upstream stall cycles.

Function
REQ-017 SHALL hold two entries: main (drives outputs) and skid (overflow), each with its own valid bit.
REQ-018 SHALL drive in_ready = NOT skid_valid, from a register with no combinational path from out_ready.
REQ-019 SHALL define accept = in_valid AND in_ready and pop = out_valid AND out_ready.
REQ-020 SHALL drive out_valid = main_valid and out_data = main payload.
REQ-021 SHALL drive out_ctrl = main ctrl when main_valid, else all zeros, so bubbles never assert RegWrite, Jump or MemtoReg.
REQ-022 SHALL give a latency of exactly 1 cycle: an entry accepted into an empty stage appears on out_* on the next edge.
REQ-023 SHALL sustain 1 entry per cycle when out_ready is held high.
REQ-024 SHALL load an accepted entry into main when main is empty or popping and skid is empty.
REQ-025 SHALL load an accepted entry into skid when main is valid and not popping.
REQ-026 SHALL move skid to main on pop when skid_valid, clearing skid_valid. No accept is possible in that cycle because in_ready=0.
REQ-027 SHALL clear main_valid on a pop when skid is empty and there is no accept.
REQ-028 SHALL keep the main payload stable while out_valid=1 and out_ready=0.
REQ-029 SHALL preserve order: main always holds the older entry.
REQ-030 SHALL on flush clear main_valid and skid_valid and drop a same-cycle accept, with flush taking priority over accept and pop.
REQ-031 SHALL leave payload registers unchanged on flush; only valid bits clear.
REQ-032 SHALL drive occupancy = main_valid + skid_valid.
REQ-033 SHALL increment stall_cnt on each cycle with in_valid=1 and in_ready=0, saturating at all-ones with no wrap, and leave it unaffected by flush.

Reset
REQ-034 SHALL on rst_n=0, immediately and without a clock, set main_valid=0, skid_valid=0, in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0 and stall_cnt=0.
REQ-035 SHALL abandon any held entries on reset assertion mid-operation and accept new entries on the first edge after rst_n rises.

Verification
REQ-036 SHALL cover streaming: out_ready=1, entries D1..D4 on consecutive cycles -> out_data D1..D4 one cycle later, out_valid continuously 1, occupancy never above 1.
REQ-037 SHALL cover backpressure: out_ready=0, accept A then B -> occupancy=2, in_ready=0, out_data=A held; third input C stalls and stall_cnt=1 per stalled cycle; raise out_ready -> outputs A, B, C in order with no loss.
REQ-038 SHALL cover flush with simultaneous accept: occupancy=2 plus in_valid=1 with flush=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, incoming entry dropped.
REQ-039 SHALL cover bubble gating: in_ctrl=3'b111 accepted then in_valid=0 with out_ready=1 -> out_ctrl=3'b111 for one cycle, then 3'b000 with out_valid=0.
REQ-040 SHALL cover saturation: CNT_W=2, hold a stall for 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
REQ-041 SHALL cover async reset mid-operation: assert rst_n=0 between edges while occupancy=2 -> outputs reach reset values before the next edge.
